// File: rtl/system_sysid_checker_pkg.sv
// Shared types and constants for the sysid integrity checker.
package system_sysid_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_LAT_ID,
    ST_RD_TS,
    ST_LAT_TS,
    ST_FINISH,
    ST_HOLDOFF
  } state_e;

  // Word addresses on the sysid control slave
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int unsigned FAIL_CNT_W = 8;
  localparam logic [FAIL_CNT_W-1:0] FAIL_CNT_MAX = '1;

  // States in which the Avalon read strobe is asserted
  function automatic logic is_read_state(state_e s);
    return (s == ST_RD_ID) || (s == ST_RD_TS);
  endfunction

endpackage

// File: rtl/system_sysid_checker_reader.sv
// One Avalon-MM read: detects accept, waitrequest timeout, and the cycle
// in which readdata is valid (accept cycle, or the last latency cycle).
// The top FSM tells it when it is in the read phase and the latency phase.
module system_sysid_checker_reader #(
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rd_i,          // read strobe is being presented this cycle
  input  logic lat_i,         // waiting out the fixed read latency
  input  logic waitrequest_i,
  output logic accept_o,      // slave accepted the read this cycle
  output logic timeout_o,     // this is the last tolerated stall cycle
  output logic capture_o      // readdata is valid this cycle
);

  localparam logic [15:0] WAIT_LAST = 16'(WAIT_TIMEOUT - 1);
  localparam logic [1:0]  LAT_LAST  = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic        lat_done;

  // Stall/latency counters restart whenever their phase is left
  always_comb begin
    accept_o   = rd_i & ~waitrequest_i;
    timeout_o  = rd_i & waitrequest_i & (wait_cnt_q == WAIT_LAST);
    lat_done   = lat_i & (lat_cnt_q == LAT_LAST);
    capture_o  = (READ_LATENCY == 0) ? accept_o : lat_done;
    wait_cnt_d = (rd_i & waitrequest_i & ~timeout_o) ? wait_cnt_q + 16'd1 : 16'd0;
    lat_cnt_d  = (lat_i & ~lat_done) ? lat_cnt_q + 2'd1 : 2'd0;
  end

  // Counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
      lat_cnt_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end

endmodule

// File: rtl/system_sysid_checker.sv
// Sysid integrity checker: reads the ID and timestamp words over Avalon-MM,
// compares them with the expected build values and reports the result.
module system_sysid_checker
  import system_sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1394144997,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned WAIT_TIMEOUT   = 255,
  parameter int unsigned RECHECK_PERIOD = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [31:0]           avm_readdata,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic                  id_ok,
  output logic                  ts_ok,
  output logic                  timeout,
  output logic [31:0]           id_value,
  output logic [31:0]           ts_value,
  output logic [FAIL_CNT_W-1:0] fail_count
);

  localparam logic [23:0] HOLD_LAST = 24'((RECHECK_PERIOD > 0) ? RECHECK_PERIOD - 1 : 0);

  state_e      state_q, state_d;
  logic [23:0] hold_cnt_q, hold_cnt_d;
  logic        rd_accept, rd_timeout, rd_capture;
  logic        avm_read_q, avm_addr_q;
  logic        abort_q;
  logic [31:0] id_stage_q, ts_stage_q;
  logic        valid_q, id_ok_q, ts_ok_q, timeout_q;
  logic [31:0] id_value_q, ts_value_q;
  logic [FAIL_CNT_W-1:0] fail_q;
  logic        id_match, ts_match;

  system_sysid_checker_reader #(
    .READ_LATENCY (READ_LATENCY),
    .WAIT_TIMEOUT (WAIT_TIMEOUT)
  ) u_reader (
    .clk_i         (clock),
    .rst_i         (reset),
    .rd_i          (is_read_state(state_q)),
    .lat_i         ((state_q == ST_LAT_ID) || (state_q == ST_LAT_TS)),
    .waitrequest_i (avm_waitrequest),
    .accept_o      (rd_accept),
    .timeout_o     (rd_timeout),
    .capture_o     (rd_capture)
  );

  // Next-state logic; the holdoff counter only advances inside HOLDOFF
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_RD_ID;
      ST_RD_ID: begin
        if (rd_timeout)     state_d = ST_FINISH;
        else if (rd_accept) state_d = (READ_LATENCY > 0) ? ST_LAT_ID : ST_RD_TS;
      end
      ST_LAT_ID: if (rd_capture) state_d = ST_RD_TS;
      ST_RD_TS: begin
        if (rd_timeout)     state_d = ST_FINISH;
        else if (rd_accept) state_d = (READ_LATENCY > 0) ? ST_LAT_TS : ST_FINISH;
      end
      ST_LAT_TS: if (rd_capture) state_d = ST_FINISH;
      ST_FINISH: state_d = (RECHECK_PERIOD > 0) ? ST_HOLDOFF : ST_IDLE;
      ST_HOLDOFF: begin
        if (start || (hold_cnt_q == HOLD_LAST)) state_d = ST_RD_ID;
        else                                    hold_cnt_d = hold_cnt_q + 24'd1;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign id_match = (id_stage_q == EXPECTED_ID);
  assign ts_match = (ts_stage_q == EXPECTED_TS);

  // Bus strobes, staging of captured words and result commit at FINISH.
  // Words are staged so an aborted check leaves the reported values intact.
  always_ff @(posedge clock) begin
    if (reset) begin
      avm_read_q <= 1'b0;
      avm_addr_q <= SYSID_ADDR_ID;
      abort_q    <= 1'b0;
      id_stage_q <= '0;
      ts_stage_q <= '0;
      valid_q    <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
      fail_q     <= '0;
    end else begin
      avm_read_q <= is_read_state(state_d);
      avm_addr_q <= (state_d == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;

      if ((state_d == ST_RD_ID) && (state_q != ST_RD_ID)) abort_q <= 1'b0;
      else if (rd_timeout)                                  abort_q <= 1'b1;

      if (rd_capture) begin
        if ((state_q == ST_RD_ID) || (state_q == ST_LAT_ID)) id_stage_q <= avm_readdata;
        else                                                  ts_stage_q <= avm_readdata;
      end

      if (state_q == ST_FINISH) begin
        valid_q   <= 1'b1;
        timeout_q <= abort_q;
        id_ok_q   <= ~abort_q & id_match;
        ts_ok_q   <= ~abort_q & ts_match;
        if (!abort_q) begin
          id_value_q <= id_stage_q;
          ts_value_q <= ts_stage_q;
        end
        if ((abort_q || !id_match || !ts_match) && (fail_q != FAIL_CNT_MAX))
          fail_q <= fail_q + 1'b1;
      end
    end
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_addr_q;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_HOLDOFF);
  assign done        = (state_q == ST_FINISH);
  assign valid       = valid_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign fail_count  = fail_q;

endmodule

// File: doc/system_sysid_checker.md
# system_sysid_checker

Boot-time and periodic integrity checker for the system ID peripheral. Acts as an Avalon-MM master on the sysid control slave: reads the ID word (address 0) and the build timestamp word (address 1), compares both against expected values, and reports match, mismatch or timeout status to the supervisor logic. Sits between the reset/boot sequencer and the sysid slave on the same clock domain.

## Interface
Parameters:
- EXPECTED_ID, 32'd0: value the ID word must equal.
- EXPECTED_TS, 32'd1394144997: value the timestamp word must equal.
- READ_LATENCY, 0: fixed cycles from read accept to valid readdata; legal range 0..3.
- WAIT_TIMEOUT, 255: consecutive waitrequest-high cycles tolerated per read; legal range 1..65535.
- RECHECK_PERIOD, 0: idle cycles between automatic rechecks; 0 disables automatic rechecks; legal range 0..2^24-1.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a check; sampled only in IDLE.
- avm_address  out  1  slave word address: 0 = ID, 1 = timestamp.
- avm_read  out  1  read strobe.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  slave read data.
- busy  out  1  check in progress.
- done  out  1  one-cycle pulse on check completion.
- valid  out  1  at least one check has completed since reset.
- id_ok  out  1  last check: ID matched.
- ts_ok  out  1  last check: timestamp matched.
- timeout  out  1  last check aborted by waitrequest timeout.
- id_value  out  32  last ID word captured.
- ts_value  out  32  last timestamp word captured.
- fail_count  out  8  saturating count of failed checks.

## Operation
- States: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FINISH, HOLDOFF.
- IDLE: start=1 -> RD_ID. start while not IDLE is ignored.
- RD_ID: avm_read=1, avm_address=0, held stable while waitrequest=1. Accept occurs when waitrequest=0. On accept: -> LAT_ID if READ_LATENCY>0; otherwise capture readdata into id_value and go to RD_TS.
- LAT_ID: count READ_LATENCY cycles, capture on the last one, then -> RD_TS. RD_TS/LAT_TS are identical with address 1, capturing ts_value.
- FINISH: one cycle. Compare the captured words; assert done; set valid=1.
- Timeout: waitrequest=1 for WAIT_TIMEOUT consecutive cycles in RD_ID or RD_TS. Deassert avm_read next cycle and go to FINISH with timeout=1 and id_ok=ts_ok=0. Captured values from the aborted check are left unchanged.
- A check fails if timeout=1 or id_ok=0 or ts_ok=0. Each failed check increments fail_count, saturating at 255.
- Status flags and values hold until the next FINISH.
- After FINISH: go to HOLDOFF if RECHECK_PERIOD>0, else IDLE.
- HOLDOFF: count RECHECK_PERIOD cycles, then go to RD_ID. start=1 in HOLDOFF goes to RD_ID immediately.
- busy=1 in RD_ID, LAT_ID, RD_TS, LAT_TS and FINISH.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-check: avm_read=0 in the cycle after the reset edge. Late readdata is ignored.
- With READ_LATENCY=0 and no waitrequest:
  - start=1 in cycle 0.
  - avm_read addr 0 in cycle 1, addr 1 in cycle 2.
  - FINISH/done in cycle 3.
  - Flags are visible in cycle 4 and stay stable thereafter.
- Each waitrequest cycle adds 1 cycle.
- Each read adds READ_LATENCY cycles, with avm_read=0 during the latency cycles.
- avm_address and avm_read are registered outputs.

## Structure
- Package system_sysid_checker_pkg holds:
  - state enum;
  - constants SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1;
  - fail-counter width.
- One natural sub-module, system_sysid_checker_reader: a single Avalon read with waitrequest timeout and fixed-latency capture. It is instantiated once and sequenced twice by the top-level FSM.

## Test plan
- Slave returns 0 for address 0 and 1394144997 for address 1, no stall, start pulse:
  - done in cycle 3;
  - id_ok=ts_ok=1, valid=1, fail_count=0.
- Slave returns timestamp 1394144998:
  - ts_ok=0, id_ok=1;
  - fail_count=1, and reaches 255 after 300 repeated checks.
- waitrequest held high for 3 cycles on each read, READ_LATENCY=2:
  - done in cycle 13;
  - captured values correct;
  - address stable while stalled.
- waitrequest stuck high, WAIT_TIMEOUT=4:
  - avm_read drops after 4 stall cycles;
  - timeout=1, done pulses, fail_count=1.
- RECHECK_PERIOD=10:
  - checks repeat every 13 cycles without start;
  - reset asserted during RD_TS gives avm_read=0 and all outputs 0 on the next cycle.
